id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Captures the main decoder's control bundle and the ID-stage operands, and presents them to EX one cycle later.
- Detects load-use hazards and inserts bubbles for them.
- Honours EX-stage hold (multicycle MUL) and branch/jump flush.

Parameters:
DATA_W, 32, width of register-file read data, immediate and PC+4
REG_AW, 5, register specifier width
CNT_W, 16, bubble counter width (used only with the optional feature)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_regwrite, id_regdst, id_alusrc, id_branch, id_memwrite, id_memtoreg, id_jump  in  1 each  decoder controls
id_aluop  in  2  decoder ALU op class
id_rd1, id_rd2  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_pc4  in  DATA_W  PC+4 of the ID instruction
id_rs, id_rt, id_rd  in  REG_AW  register specifiers
ex_hold  in  1  EX cannot accept a new instruction this cycle
flush  in  1  kill the ID instruction (taken branch or jump)
ex_valid  out  1  EX register holds a real instruction
ex_regwrite, ex_regdst, ex_alusrc, ex_branch, ex_memwrite, ex_memtoreg, ex_jump  out  1 each  registered controls
ex_aluop  out  2  registered ALU op
ex_rd1, ex_rd2, ex_imm, ex_pc4  out  DATA_W  registered operands
ex_rs, ex_rt, ex_rd  out  REG_AW  registered specifiers
id_stall  out  1  combinational: freeze PC and IF/ID this cycle
load_use  out  1  combinational: load-use hazard detected
bubble_cnt  out  CNT_W  bubbles inserted (optional feature)

Behaviour:
- Clock and reset:
  - Single clock domain; rst_n is asynchronous and active-low.
  - On reset every ex_* output, ex_valid and bubble_cnt = 0.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Input gating:
  - When id_valid=0, decoder inputs are ignored; an X from an illegal opcode never reaches ex_*.
  - Such a cycle loads a bubble.
- Hazard logic (combinational, from current EX contents):
  - ex_dest = ex_regdst ? ex_rd : ex_rt.
  - uses_rs = ~id_jump.
  - uses_rt = (~id_alusrc & ~id_jump) | id_memwrite.
  - load_use = ex_valid & ex_memtoreg & ex_regwrite & (ex_dest != 0) & id_valid & ((uses_rs & ex_dest==id_rs) | (uses_rt & ex_dest==id_rt)).
  - id_stall = load_use | ex_hold.
- Per-edge update, highest priority first:
  1. ex_hold=1: all registers keep their values. flush is ignored; its source keeps it asserted until a non-hold cycle.
  2. flush=1: load a bubble.
  3. load_use=1: load a bubble. ID is held by id_stall and re-presents the instruction next cycle.
  4. id_valid=0: load a bubble.
  5. Otherwise: load every id_* field, ex_valid=1.
- Bubble definition: ex_valid=0 and every control, operand and specifier field = 0.
- Only one bubble per load-use. The following cycle the load has left EX, so load_use deasserts.
- Simultaneous flush and load_use: a single bubble is loaded; ID is killed upstream by flush.
- Reset asserted mid-operation clears state immediately, independent of clk.

Optional Feature:
- Macro: IDEX_BUBBLE_CNT_EN.
- Defined:
  - bubble_cnt increments by 1 on every edge that loads a bubble due to flush or load_use with ex_hold=0.
  - Bubbles caused by id_valid=0 are not counted.
  - Saturates at all-ones; cleared only by reset.
- Undefined: bubble_cnt is tied to 0 and no counter flops are built.

Test Plan:
- Reset then LW (memtoreg=1, regwrite=1, alusrc=1, rt=8) with id_valid=1 -> next cycle ex_valid=1, ex_memtoreg=1, ex_rt=8, ex_aluop=00.
- LW rt=8 in EX, ID = ADD rs=8 rt=9 -> load_use=1, id_stall=1; next edge ex_valid=0 with all ex_* = 0; following edge ADD loads; bubble_cnt=1 when the macro is defined.
- LW rt=0 in EX, ID = ADD rs=0 -> load_use=0, no bubble.
- LW rt=8 in EX, ID = ADDI rs=3 rt=8 -> load_use=0, because uses_rt=0.
- ex_hold=1 for 3 cycles with flush=1 -> ex_* unchanged and id_stall=1 throughout; first edge with ex_hold=0 loads a bubble.
- id_valid=0 with decoder outputs all X -> ex_* all 0, no X propagated; rst_n pulled low mid-stream -> outputs 0 immediately without a clock edge.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg -- ID/EX pipeline register of the 5-stage MIPS core.
//
// Captures the decoder control bundle and ID operands and presents them to EX
// one cycle later. Detects load-use hazards against the instruction currently
// in EX and inserts a single bubble for each one. It also honours an EX hold
// (multicycle MUL) and a branch/jump flush.
//
// Optional feature (macro IDEX_BUBBLE_CNT_EN): a saturating counter of the
// bubbles inserted by flush or load-use. Without the macro, bubble_cnt is
// tied to zero and no counter flops exist.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_<ctrl>/aluop   decoder controls
//   id_rd1/rd2/imm/pc4  operands, DATA_W bits each
//   id_rs/rt/rd       register specifiers
//   ex_hold           EX cannot accept a new instruction
//   flush             kill the ID instruction
//   ex_*              registered copy of the above, plus ex_valid
//   id_stall          combinational: freeze PC and IF/ID
//   load_use          combinational: load-use hazard detected
//   bubble_cnt        counted bubbles (optional feature)
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_regwrite,
  input  logic              id_regdst,
  input  logic              id_alusrc,
  input  logic              id_branch,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_jump,
  input  logic [1:0]        id_aluop,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_regdst,
  output logic              ex_alusrc,
  output logic              ex_branch,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_jump,
  output logic [1:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              id_stall,
  output logic              load_use,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              regdst;
    logic              alusrc;
    logic              branch;
    logic              memwrite;
    logic              memtoreg;
    logic              jump;
    logic [1:0]        aluop;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } ex_regs_t;

  ex_regs_t          ex_q;
  ex_regs_t          ex_d;
  ex_regs_t          id_s;
  logic [REG_AW-1:0] ex_dest_s;
  logic              uses_rs_s;
  logic              uses_rt_s;
  logic              load_use_s;

  // Gate the decoder bundle with id_valid so X from an illegal opcode never reaches EX
  always_comb begin
    id_s = '0;
    if (id_valid) begin
      id_s.valid    = 1'b1;
      id_s.regwrite = id_regwrite;
      id_s.regdst   = id_regdst;
      id_s.alusrc   = id_alusrc;
      id_s.branch   = id_branch;
      id_s.memwrite = id_memwrite;
      id_s.memtoreg = id_memtoreg;
      id_s.jump     = id_jump;
      id_s.aluop    = id_aluop;
      id_s.rd1      = id_rd1;
      id_s.rd2      = id_rd2;
      id_s.imm      = id_imm;
      id_s.pc4      = id_pc4;
      id_s.rs       = id_rs;
      id_s.rt       = id_rt;
      id_s.rd       = id_rd;
    end else begin
      id_s = '0;
    end
  end

  // Load-use detection against the load currently sitting in EX
  always_comb begin
    ex_dest_s  = ex_q.regdst ? ex_q.rd : ex_q.rt;
    uses_rs_s  = ~id_jump;
    // Stores read rt as data even though the ALU takes the immediate
    uses_rt_s  = (~id_alusrc & ~id_jump) | id_memwrite;
    load_use_s = ex_q.valid & ex_q.memtoreg & ex_q.regwrite &
                 (ex_dest_s != {REG_AW{1'b0}}) & id_valid &
                 ((uses_rs_s & (ex_dest_s == id_rs)) |
                  (uses_rt_s & (ex_dest_s == id_rt)));
  end

  // Next-state selection: hold, then bubble (flush/load-use), then ID capture
  always_comb begin
    ex_d = ex_q;
    if (ex_hold) begin
      ex_d = ex_q;
    end else if (flush | load_use_s) begin
      ex_d = '0;
    end else begin
      ex_d = id_s;  // already a bubble when id_valid is low
    end
  end

  // ID/EX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

`ifdef IDEX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_inc_s;

  // Saturating count of hazard/flush bubbles; id_valid=0 bubbles are excluded
  always_comb begin
    cnt_d     = cnt_q;
    cnt_inc_s = ~ex_hold & (flush | load_use_s);
    if (cnt_inc_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Bubble counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;
`else
  assign bubble_cnt = {CNT_W{1'b0}};
`endif

  assign ex_valid    = ex_q.valid;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_regdst   = ex_q.regdst;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_branch   = ex_q.branch;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_jump     = ex_q.jump;
  assign ex_aluop    = ex_q.aluop;
  assign ex_rd1      = ex_q.rd1;
  assign ex_rd2      = ex_q.rd2;
  assign ex_imm      = ex_q.imm;
  assign ex_pc4      = ex_q.pc4;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_rd       = ex_q.rd;
  assign load_use    = load_use_s;
  assign id_stall    = load_use_s | ex_hold;

endmodule
